// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
// Round-robin scheduler that shares a single fpu between several clients.
// Each client hands over one operation (operand A, operand B, 4-bit operation
// code) through a req_rdy/req_ack handshake. The arbiter picks one client,
// drives the fpu input handshake, keeps operands and operation stable for the
// whole fpu run, captures the fpu result and returns it to that client through
// a resp_rdy/resp_ack handshake. Only one fpu operation is ever outstanding.
//
// Optional feature macro: FPU_ARB_TIMEOUT_EN
//   defined   -> watchdog counts cycles spent in issue/wait_result; when it
//                reaches timeout_cycles, the client receives a quiet NaN
//                with resp_error=1.
//   undefined -> no watchdog, the arbiter waits indefinitely, resp_error=0.
//
// Parameters:
//   bitness         operand/result width
//   requesters      number of clients (2..16)
//   timeout_cycles  watchdog limit (only used with FPU_ARB_TIMEOUT_EN)
//
// Ports:
//   clock, reset        system clock; synchronous active-low reset
//   req_rdy/req_ack     per-client request valid / one-cycle accept pulse
//   req_data_a/b        per-client operands, client i at [i*bitness +: bitness]
//   req_operation       per-client operation code, client i at [i*4 +: 4]
//   resp_rdy/resp_ack   per-client result valid / client accepts result
//   resp_result         result for the client whose resp_rdy is high
//   resp_error          result was produced by the watchdog
//   fpu_*               handshake and data towards the shared fpu
//   busy                high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module fpu_arbiter #(
    parameter int bitness        = 32,
    parameter int requesters     = 4,
    parameter int timeout_cycles = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [requesters-1:0]         req_rdy,
    output logic [requesters-1:0]         req_ack,
    input  logic [requesters*bitness-1:0] req_data_a,
    input  logic [requesters*bitness-1:0] req_data_b,
    input  logic [requesters*4-1:0]       req_operation,
    output logic [requesters-1:0]         resp_rdy,
    input  logic [requesters-1:0]         resp_ack,
    output logic [bitness-1:0]            resp_result,
    output logic                          resp_error,
    output logic                          fpu_input_rdy,
    input  logic                          fpu_input_ack,
    output logic [bitness-1:0]            fpu_data_a,
    output logic [bitness-1:0]            fpu_data_b,
    output logic [3:0]                    fpu_operation,
    input  logic                          fpu_output_rdy,
    output logic                          fpu_output_ack,
    input  logic [bitness-1:0]            fpu_result,
    output logic                          busy
);

    localparam int              PTR_W     = (requesters > 1) ? $clog2(requesters) : 1;
    localparam logic [3:0]      ADD_OP    = 4'h0;
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(requesters - 1);
    localparam logic [requesters-1:0] ONE_HOT_C = {{(requesters-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT_RESULT = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_DELIVER     = 3'd4
    } state_t;

    // First requesting client after ptr, wrapping modulo requesters.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [requesters-1:0] rdy,
                                                 input logic [PTR_W-1:0]      ptr);
        int cand;
        for (int i = 1; i <= requesters; i++) begin
            cand = (int'(ptr) + i) % requesters;
            if (rdy[cand]) begin
                return cand[PTR_W-1:0];
            end
        end
        return ptr;
    endfunction

    function automatic logic [requesters-1:0] one_hot(input logic [PTR_W-1:0] idx);
        return ONE_HOT_C << idx;
    endfunction

    state_t                  state_r, state_next_s;
    logic [PTR_W-1:0]        pointer_r, pointer_next_s;
    logic [PTR_W-1:0]        grant_r, grant_next_s;
    logic [PTR_W-1:0]        pick_s;
    logic [requesters-1:0]   req_ack_r, req_ack_next_s;
    logic [requesters-1:0]   resp_rdy_r, resp_rdy_next_s;
    logic [bitness-1:0]      resp_result_r, resp_result_next_s;
    logic [bitness-1:0]      data_a_r, data_a_next_s;
    logic [bitness-1:0]      data_b_r, data_b_next_s;
    logic [3:0]              operation_r, operation_next_s;
    logic                    input_rdy_r, input_rdy_next_s;
    logic                    output_ack_r, output_ack_next_s;
    logic                    busy_r, busy_next_s;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(timeout_cycles + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(timeout_cycles - 1);

    // Quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
    localparam int EXP_W = (bitness == 16) ? 5 : ((bitness == 64) ? 11 : 8);
    function automatic logic [bitness-1:0] quiet_nan();
        logic [bitness-1:0] v;
        v = '0;
        v[bitness-2 -: EXP_W+1] = '1;
        return v;
    endfunction

    logic [TMR_W-1:0] timer_r, timer_next_s;
    logic             error_r, error_next_s;
`endif

    // Round-robin candidate for the next grant.
    always_comb begin
        pick_s = rr_pick(req_rdy, pointer_r);
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_next_s       = state_r;
        pointer_next_s     = pointer_r;
        grant_next_s       = grant_r;
        req_ack_next_s     = '0;
        resp_rdy_next_s    = resp_rdy_r;
        resp_result_next_s = resp_result_r;
        data_a_next_s      = data_a_r;
        data_b_next_s      = data_b_r;
        operation_next_s   = operation_r;
        input_rdy_next_s   = input_rdy_r;
        output_ack_next_s  = output_ack_r;
`ifdef FPU_ARB_TIMEOUT_EN
        timer_next_s       = timer_r;
        error_next_s       = error_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (|req_rdy) begin
                    grant_next_s     = pick_s;
                    pointer_next_s   = pick_s;
                    data_a_next_s    = req_data_a[int'(pick_s)*bitness +: bitness];
                    data_b_next_s    = req_data_b[int'(pick_s)*bitness +: bitness];
                    operation_next_s = req_operation[int'(pick_s)*4 +: 4];
                    req_ack_next_s   = one_hot(pick_s);
                    input_rdy_next_s = 1'b1;
                    state_next_s     = ST_ISSUE;
`ifdef FPU_ARB_TIMEOUT_EN
                    timer_next_s     = '0;
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fpu_input_ack) begin
                    input_rdy_next_s = 1'b0;
                    state_next_s     = ST_WAIT_RESULT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT_RESULT: begin
                if (fpu_output_rdy) begin
                    resp_result_next_s = fpu_result;
                    output_ack_next_s  = 1'b1;
                    state_next_s       = ST_RELEASE;
                end else begin
                    state_next_s = ST_WAIT_RESULT;
                end
            end
            ST_RELEASE: begin
                // Keep the ack up until the fpu has withdrawn its result.
                if (!fpu_output_rdy) begin
                    output_ack_next_s = 1'b0;
                    resp_rdy_next_s   = one_hot(grant_r);
                    state_next_s      = ST_DELIVER;
                end else begin
                    state_next_s = ST_RELEASE;
                end
            end
            ST_DELIVER: begin
                if (resp_ack[grant_r]) begin
                    resp_rdy_next_s = '0;
                    state_next_s    = ST_IDLE;
`ifdef FPU_ARB_TIMEOUT_EN
                    error_next_s    = 1'b0;
`endif
                end else begin
                    state_next_s = ST_DELIVER;
                end
            end
            default: begin
                state_next_s      = ST_IDLE;
                resp_rdy_next_s   = '0;
                input_rdy_next_s  = 1'b0;
                output_ack_next_s = 1'b0;
            end
        endcase
`ifdef FPU_ARB_TIMEOUT_EN
        // Watchdog overrides the normal progression of issue/wait_result.
        if ((state_r == ST_ISSUE) || (state_r == ST_WAIT_RESULT)) begin
            if (timer_r == TMR_LAST) begin
                input_rdy_next_s   = 1'b0;
                output_ack_next_s  = 1'b0;
                resp_result_next_s = quiet_nan();
                error_next_s       = 1'b1;
                resp_rdy_next_s    = one_hot(grant_r);
                state_next_s       = ST_DELIVER;
            end else begin
                timer_next_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            timer_next_s = timer_next_s;
        end
`endif
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            pointer_r     <= PTR_INIT;
            grant_r       <= '0;
            req_ack_r     <= '0;
            resp_rdy_r    <= '0;
            resp_result_r <= '0;
            data_a_r      <= '0;
            data_b_r      <= '0;
            operation_r   <= ADD_OP;
            input_rdy_r   <= 1'b0;
            output_ack_r  <= 1'b0;
            busy_r        <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            timer_r       <= '0;
            error_r       <= 1'b0;
`endif
        end else begin
            state_r       <= state_next_s;
            pointer_r     <= pointer_next_s;
            grant_r       <= grant_next_s;
            req_ack_r     <= req_ack_next_s;
            resp_rdy_r    <= resp_rdy_next_s;
            resp_result_r <= resp_result_next_s;
            data_a_r      <= data_a_next_s;
            data_b_r      <= data_b_next_s;
            operation_r   <= operation_next_s;
            input_rdy_r   <= input_rdy_next_s;
            output_ack_r  <= output_ack_next_s;
            busy_r        <= busy_next_s;
`ifdef FPU_ARB_TIMEOUT_EN
            timer_r       <= timer_next_s;
            error_r       <= error_next_s;
`endif
        end
    end

    assign req_ack        = req_ack_r;
    assign resp_rdy       = resp_rdy_r;
    assign resp_result    = resp_result_r;
    assign fpu_input_rdy  = input_rdy_r;
    assign fpu_data_a     = data_a_r;
    assign fpu_data_b     = data_b_r;
    assign fpu_operation  = operation_r;
    assign fpu_output_ack = output_ack_r;
    assign busy           = busy_r;
`ifdef FPU_ARB_TIMEOUT_EN
    assign resp_error     = error_r;
`else
    assign resp_error     = 1'b0;
`endif

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Round-robin scheduler sharing one fpu instance between REQUESTERS independent clients. Each client issues one operation (operands plus Operation_t code) over a ready/ack handshake. The arbiter grants one client, drives the fpu input handshake, holds operands and operation stable for the full fpu run, captures the fpu result, and returns it to the granted client. Single outstanding fpu operation at any time.

Parameters:
bitness, 32, operand/result width; passed through to fpu.
requesters, 4, number of clients (2..16).
timeout_cycles, 64, fpu watchdog limit in cycles; used only with FPU_ARB_TIMEOUT_EN.

Ports:
clock  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-low: reset==0 at a posedge resets the block.
req_rdy  in  requesters  per-client request valid; held until req_ack.
req_ack  out  requesters  one-cycle pulse: operands of that client latched.
req_data_a  in  requesters*bitness  per-client operand A.
req_data_b  in  requesters*bitness  per-client operand B.
req_operation  in  requesters*4  per-client Operation_t code.
resp_rdy  out  requesters  per-client result valid; held until resp_ack.
resp_ack  in  requesters  client accepts result.
resp_result  out  bitness  result; valid for the client whose resp_rdy is high.
resp_error  out  1  result produced by watchdog; 0 without FPU_ARB_TIMEOUT_EN.
fpu_input_rdy  out  1  to fpu input_rdy.
fpu_input_ack  in  1  from fpu input_ack.
fpu_data_a  out  bitness  to fpu data_a.
fpu_data_b  out  bitness  to fpu data_b.
fpu_operation  out  4  to fpu operation.
fpu_output_rdy  in  1  from fpu output_rdy.
fpu_output_ack  out  1  to fpu output_ack.
fpu_result  in  bitness  from fpu result.
busy  out  1  high in any state other than idle.

Behaviour:
- Reset (reset==0): state=idle; req_ack, resp_rdy, fpu_input_rdy, fpu_output_ack, busy, resp_error =0; resp_result, fpu_data_a/b =0; fpu_operation=add_op; grant pointer = requesters-1 (client 0 wins first). Reset mid-operation aborts the transaction; no response delivered; fpu reset is external.
- States: idle, issue, wait_result, release, deliver.
- idle: if any req_rdy set, pick first set bit searching from pointer+1 modulo requesters; latch its a/b/operation into fpu_data_a/b/fpu_operation, store grant index, pulse req_ack[grant] for exactly 1 cycle, update pointer=grant -> issue. Otherwise stay, outputs idle.
- issue: fpu_input_rdy=1; on fpu_input_ack==1 -> wait_result, fpu_input_rdy=0 next cycle.
- wait_result: on fpu_output_rdy==1 capture fpu_result into resp_result, fpu_output_ack=1 -> release.
- release: hold fpu_output_ack=1 until fpu_output_rdy==0, then fpu_output_ack=0 -> deliver.
- deliver: resp_rdy[grant]=1; on resp_ack[grant]==1 clear resp_rdy -> idle. resp_ack on other clients ignored.
- fpu_data_a/b/fpu_operation stable from idle exit until deliver exit.
- Minimum latency req_rdy to req_ack: 1 cycle. New grant earliest the cycle after resp_ack.
- Requests arriving during busy wait; req_rdy dropped before req_ack is legal and loses no state.
- All clients requesting continuously: grants strictly rotate 0,1,2,...,requesters-1,0.
- Operation codes passed through unchecked; fpu handles reserved codes.

Optional Feature:
FPU_ARB_TIMEOUT_EN: defined -> counter clears on entering issue, increments each cycle in issue/wait_result; reaching timeout_cycles -> fpu_input_rdy=0, resp_result = quiet NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0), resp_error=1, go to deliver (skip release). resp_error clears with resp_rdy. Not defined -> no counter, waits indefinitely, resp_error tied 0.

Test Plan:
- Single client 0: a=0x40000000, b=0x3F800000, add_op -> req_ack[0] one cycle after req_rdy; fpu_input_rdy high until ack; resp_rdy[0] with resp_result==fpu_result; busy 0 after resp_ack.
- All 4 clients request continuously, 8 ops -> grant order 0,1,2,3,0,1,2,3; one req_ack per grant.
- Client 2 requests during client 1 op -> no req_ack[2] until client 1 resp_ack; fpu_data_a unchanged during client 1 op.
- resp_ack delayed 5 cycles -> resp_rdy[grant] and resp_result held stable; no new grant.
- reset=0 during wait_result -> next cycle all outputs at reset values; subsequent request from client 3 served normally, client 0 first if both pending.
- FPU_ARB_TIMEOUT_EN, timeout_cycles=16, fpu_output_rdy never set -> resp_rdy after 16 cycles in issue/wait_result, resp_result=0x7FC00000, resp_error=1.
